// File: rtl/sparc_fetch_pkg.sv
// Shared definitions for the SPARC instruction fetch unit.
//   fetch_state_t : fetch FSM encoding (IDLE=0, FETCH=1, HALTED=2)
//   INSTR_W       : instruction word width
//   NOP_WORD      : word placed in IF/ID when a delay slot is annulled
//   PC_STEP       : byte increment between sequential fetches
package sparc_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0;
  localparam int PC_STEP = 4;

endpackage

// File: rtl/sparc_fetch_unit_if.sv
// Fetch-side bus bundle: instruction ROM port, branch redirect request from
// the decode stage and the IF/ID register outputs.
//   master : the fetch unit (drives rom_addr and the IF/ID outputs)
//   slave  : the environment (ROM + decode/branch logic)
interface sparc_fetch_unit_if #(
  parameter int ADDR_W = 9
);
  import sparc_fetch_pkg::*;

  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic               br_taken;
  logic [ADDR_W-1:0]  br_target;
  logic               br_annul;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;

  modport master (
    output rom_addr, instr, instr_pc, instr_valid,
    input  rom_data, br_taken, br_target, br_annul
  );

  modport slave (
    input  rom_addr, instr, instr_pc, instr_valid,
    output rom_data, br_taken, br_target, br_annul
  );

endinterface

// File: rtl/fetch_redirect_reg.sv
// Pending branch redirect holder.
// A branch that resolves while the pipe is stalled cannot redirect the PC yet,
// so it is parked here until the first non-stalled fetch. A live br_taken
// always wins over a parked one.
//   clk, clr     : clock, synchronous active-low reset
//   capture      : park br_target/br_annul (overwrites any earlier one)
//   consume      : a redirect was applied this cycle; drop the parked one
//   br_*         : live branch request
//   redir_*      : selected redirect (live if present, else parked)
module fetch_redirect_reg #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              capture,
  input  logic              consume,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              br_annul,
  output logic              redir_valid,
  output logic [ADDR_W-1:0] redir_tgt,
  output logic              redir_annul
);

  logic              pend_reg;
  logic [ADDR_W-1:0] pend_tgt_reg;
  logic              pend_annul_reg;

  always_ff @(posedge clk) begin
    if (!clr) begin
      pend_reg       <= 1'b0;
      pend_tgt_reg   <= '0;
      pend_annul_reg <= 1'b0;
    end else if (capture) begin
      pend_reg       <= 1'b1;
      pend_tgt_reg   <= br_target;
      pend_annul_reg <= br_annul;
    end else if (consume) begin
      pend_reg <= 1'b0;
    end
  end

  always_comb begin
    redir_valid = 1'b0;
    redir_tgt   = '0;
    redir_annul = 1'b0;
    if (br_taken) begin
      redir_valid = 1'b1;
      redir_tgt   = br_target;
      redir_annul = br_annul;
    end else if (pend_reg) begin
      redir_valid = 1'b1;
      redir_tgt   = pend_tgt_reg;
      redir_annul = pend_annul_reg;
    end
  end

endmodule

// File: rtl/sparc_fetch_unit.sv
// SPARC instruction fetch stage.
// Owns the PC, presents it to a zero-latency byte-addressed ROM and captures
// the returned word into the IF/ID register. Supports stall, taken branches
// with one delay slot (optionally annulled) and a sticky halt.
//   clk   : rising-edge clock
//   clr   : synchronous active-low reset
//   start : leave IDLE and begin fetching
//   halt  : stop fetching until reset
//   stall : hold PC and IF/ID
//   bus   : ROM port, branch request and IF/ID outputs (master modport)
//   state : IDLE=0, FETCH=1, HALTED=2
module sparc_fetch_unit
  import sparc_fetch_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int RESET_PC = 0
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      start,
  input  logic                      halt,
  input  logic                      stall,
  sparc_fetch_unit_if.master        bus,
  output logic [1:0]                state
);

  fetch_state_t       state_reg, state_next;
  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic [INSTR_W-1:0] instr_reg, instr_next;
  logic [ADDR_W-1:0]  instr_pc_reg, instr_pc_next;
  logic               instr_valid_reg, instr_valid_next;

  logic               capture;
  logic               consume;
  logic               redir_valid;
  logic [ADDR_W-1:0]  redir_tgt;
  logic               redir_annul;

  fetch_redirect_reg #(.ADDR_W(ADDR_W)) u_redirect (
    .clk         (clk),
    .clr         (clr),
    .capture     (capture),
    .consume     (consume),
    .br_taken    (bus.br_taken),
    .br_target   (bus.br_target),
    .br_annul    (bus.br_annul),
    .redir_valid (redir_valid),
    .redir_tgt   (redir_tgt),
    .redir_annul (redir_annul)
  );

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_reg       <= IDLE;
      pc_reg          <= ADDR_W'(RESET_PC);
      instr_reg       <= NOP_WORD;
      instr_pc_reg    <= '0;
      instr_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      instr_reg       <= instr_next;
      instr_pc_reg    <= instr_pc_next;
      instr_valid_reg <= instr_valid_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    instr_next       = instr_reg;
    instr_pc_next    = instr_pc_reg;
    instr_valid_next = instr_valid_reg;
    capture          = 1'b0;
    consume          = 1'b0;

    unique case (state_reg)
      IDLE: begin
        instr_valid_next = 1'b0;
        if (start) state_next = FETCH;
      end
      FETCH: begin
        if (halt) begin
          state_next       = HALTED;
          instr_valid_next = 1'b0;
        end else if (stall) begin
          // Everything holds; a branch seen now is parked for later.
          capture = bus.br_taken;
        end else begin
          instr_next       = bus.rom_data;
          instr_pc_next    = pc_reg;
          instr_valid_next = 1'b1;
          if (redir_valid) begin
            // Word captured now is the delay slot; the target is fetched next.
            pc_next = redir_tgt & ~ADDR_W'(3);
            consume = 1'b1;
            if (redir_annul) begin
              instr_next       = NOP_WORD;
              instr_valid_next = 1'b0;
            end
          end else begin
            pc_next = pc_reg + ADDR_W'(PC_STEP);
          end
        end
      end
      HALTED: begin
        instr_valid_next = 1'b0;
      end
      default: begin
        state_next       = IDLE;
        instr_valid_next = 1'b0;
      end
    endcase
  end

  assign bus.rom_addr    = pc_reg;
  assign bus.instr       = instr_reg;
  assign bus.instr_pc    = instr_pc_reg;
  assign bus.instr_valid = instr_valid_reg;
  assign state           = state_reg;

endmodule

// File: tb/tb_sparc_fetch_unit.sv
module tb_sparc_fetch_unit;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic       halt;
  logic       stall;
  logic [1:0] state;

  sparc_fetch_unit_if #(.ADDR_W(9)) bus ();

  sparc_fetch_unit #(.ADDR_W(9), .RESET_PC(0)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .halt  (halt),
    .stall (stall),
    .bus   (bus),
    .state (state)
  );

  always #5 clk = ~clk;

  // ROM contents: each word tags its own byte address.
  function automatic logic [31:0] w(input logic [8:0] a);
    return {16'hC0DE, 7'b0, a};
  endfunction

  assign bus.rom_data = w(bus.rom_addr);

  typedef struct {
    logic        clr;
    logic        start;
    logic        halt;
    logic        stall;
    logic        br;
    logic        annul;
    logic [8:0]  tgt;
    logic [8:0]  e_addr;
    logic [31:0] e_instr;
    logic [8:0]  e_ipc;
    logic        e_v;
    logic [1:0]  e_st;
  } vec_t;

  vec_t vecs[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic add(input logic c, input logic s, input logic h, input logic st,
                     input logic b, input logic an, input logic [8:0] tg,
                     input logic [8:0] ea, input logic [31:0] ei, input logic [8:0] ep,
                     input logic ev, input logic [1:0] es);
    vec_t v;
    v.clr = c; v.start = s; v.halt = h; v.stall = st; v.br = b; v.annul = an; v.tgt = tg;
    v.e_addr = ea; v.e_instr = ei; v.e_ipc = ep; v.e_v = ev; v.e_st = es;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [8:0] ea, input logic [31:0] ei,
                         input logic [8:0] ep, input logic ev, input logic [1:0] es);
    chk({tag, " rom_addr"}, 32'(bus.rom_addr), 32'(ea));
    chk({tag, " instr"}, bus.instr, ei);
    chk({tag, " instr_pc"}, 32'(bus.instr_pc), 32'(ep));
    chk({tag, " instr_valid"}, 32'(bus.instr_valid), 32'(ev));
    chk({tag, " state"}, 32'(state), 32'(es));
  endtask

  task automatic drive(input logic c, input logic s, input logic h, input logic st,
                       input logic b, input logic an, input logic [8:0] tg);
    clr = c; start = s; halt = h; stall = st;
    bus.br_taken = b; bus.br_annul = an; bus.br_target = tg;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    $display("[TB] t=%0t addr=%0d instr=%h ipc=%0d v=%0b st=%0d",
             $time, bus.rom_addr, bus.instr, bus.instr_pc, bus.instr_valid, state);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0);

    //   clr st  hl  sl  br  an  tgt      addr    instr     ipc     v   state
    add(0, 0, 0, 0, 0, 0, 9'd0,   9'd0,   32'h0,    9'd0,   0, 2'd0); // reset
    add(0, 0, 0, 0, 0, 0, 9'd0,   9'd0,   32'h0,    9'd0,   0, 2'd0);
    add(1, 0, 0, 0, 0, 0, 9'd0,   9'd0,   32'h0,    9'd0,   0, 2'd0); // idle
    add(1, 1, 0, 0, 0, 0, 9'd0,   9'd0,   32'h0,    9'd0,   0, 2'd1); // enter FETCH
    add(1, 0, 0, 0, 0, 0, 9'd0,   9'd4,   w(9'd0),  9'd0,   1, 2'd1); // W0
    add(1, 0, 0, 0, 0, 0, 9'd0,   9'd8,   w(9'd4),  9'd4,   1, 2'd1); // W1
    add(1, 0, 0, 0, 1, 0, 9'd64,  9'd64,  w(9'd8),  9'd8,   1, 2'd1); // delay slot
    add(1, 0, 0, 0, 0, 0, 9'd0,   9'd68,  w(9'd64), 9'd64,  1, 2'd1); // target
    add(1, 1, 0, 0, 0, 0, 9'd0,   9'd72,  w(9'd68), 9'd68,  1, 2'd1); // start ignored
    add(1, 0, 0, 0, 1, 1, 9'd130, 9'd128, 32'h0,    9'd72,  0, 2'd1); // annulled, aligned tgt
    add(1, 0, 0, 0, 0, 0, 9'd0,   9'd132, w(9'd128),9'd128, 1, 2'd1);
    add(1, 0, 0, 1, 1, 0, 9'd200, 9'd132, w(9'd128),9'd128, 1, 2'd1); // stall + br
    add(1, 0, 0, 1, 1, 0, 9'd256, 9'd132, w(9'd128),9'd128, 1, 2'd1); // override
    add(1, 0, 0, 1, 0, 0, 9'd0,   9'd132, w(9'd128),9'd128, 1, 2'd1);
    add(1, 0, 0, 0, 0, 0, 9'd0,   9'd256, w(9'd132),9'd132, 1, 2'd1); // slot, pend used
    add(1, 0, 0, 0, 0, 0, 9'd0,   9'd260, w(9'd256),9'd256, 1, 2'd1);
    add(1, 0, 0, 1, 1, 1, 9'd500, 9'd260, w(9'd256),9'd256, 1, 2'd1); // parked annul
    add(1, 0, 0, 0, 0, 0, 9'd0,   9'd500, 32'h0,    9'd260, 0, 2'd1);
    add(1, 0, 0, 0, 0, 0, 9'd0,   9'd504, w(9'd500),9'd500, 1, 2'd1);
    add(1, 0, 0, 0, 0, 0, 9'd0,   9'd508, w(9'd504),9'd504, 1, 2'd1);
    add(1, 0, 0, 0, 0, 0, 9'd0,   9'd0,   w(9'd508),9'd508, 1, 2'd1); // wrap
    add(1, 0, 0, 0, 0, 0, 9'd0,   9'd4,   w(9'd0),  9'd0,   1, 2'd1);
    add(1, 0, 0, 1, 1, 0, 9'd300, 9'd4,   w(9'd0),  9'd0,   1, 2'd1); // park 300
    add(1, 0, 0, 0, 1, 0, 9'd16,  9'd16,  w(9'd4),  9'd4,   1, 2'd1); // live wins
    add(1, 0, 0, 0, 0, 0, 9'd0,   9'd20,  w(9'd16), 9'd16,  1, 2'd1); // pend cleared
    add(1, 0, 0, 0, 0, 1, 9'd0,   9'd24,  w(9'd20), 9'd20,  1, 2'd1); // annul w/o br
    add(1, 0, 1, 0, 0, 0, 9'd0,   9'd24,  w(9'd20), 9'd20,  0, 2'd2); // halt

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].start, vecs[i].halt, vecs[i].stall,
            vecs[i].br, vecs[i].annul, vecs[i].tgt);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_instr,
              vecs[i].e_ipc, vecs[i].e_v, vecs[i].e_st);
    end

    // Halted: frozen for 10 cycles whatever the other inputs do.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
            1'b1, 1'($urandom_range(1)), 9'($urandom_range(511)));
      step();
      chk_all($sformatf("halt%0d", i), 9'd24, w(9'd20), 9'd20, 1'b0, 2'd2);
    end

    // Reset out of HALTED.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0);
    step();
    chk_all("clr_halt", 9'd0, 32'h0, 9'd0, 1'b0, 2'd0);

    // Reset while stalled with a redirect parked: target must be forgotten.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0); step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0); step();
    step();
    chk_all("pre_stall", 9'd8, w(9'd4), 9'd4, 1'b1, 2'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'd100); step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0); step();
    chk_all("clr_stall", 9'd0, 32'h0, 9'd0, 1'b0, 2'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0); step();
    chk_all("restart", 9'd0, 32'h0, 9'd0, 1'b0, 2'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("resume%0d", i), 9'(4 * (i + 1)), w(9'(4 * i)), 9'(4 * i),
              1'b1, 2'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sparc_fetch_unit.md
Name: sparc_fetch_unit

Overview:
- Initiator side of the byte-addressed instruction ROM interface.
- Owns the program counter and drives the 9-bit byte address. Assembles nothing itself: the ROM returns 4 big-endian bytes combinationally.
- Registers the returned word into an IF/ID instruction register that feeds control_unit.instr.
- Handles pipeline stall, taken-branch redirect with one SPARC delay slot, delay-slot annul, and halt.

Parameters:
- ADDR_W, 9, byte address width; PC wraps modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded on reset; must be word aligned.

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  reset; synchronous, active-low (clr=0 sampled at rising clk resets)
- start  input  1  leave IDLE and begin fetching
- halt  input  1  stop fetching permanently until reset
- stall  input  1  hold IF/ID register and PC
- br_taken  input  1  redirect fetch to br_target after the delay slot
- br_target  input  ADDR_W  branch target byte address
- br_annul  input  1  with br_taken: squash the delay-slot instruction
- rom_addr  output  ADDR_W  byte address to ROM (= PC)
- rom_data  input  32  combinational ROM word at rom_addr
- instr  output  32  IF/ID instruction to control_unit
- instr_pc  output  ADDR_W  address of instr
- instr_valid  output  1  instr is a real instruction
- state  output  2  IDLE=0, FETCH=1, HALTED=2

Behaviour:
- Reset (clr=0 at edge): pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, pending redirect cleared, state=IDLE. Reset takes priority in every state, including mid-stall with a redirect pending.
- rom_addr = pc, purely combinational from the register.
- ROM read is zero-latency. The word at pc is captured at the same edge that advances pc, so instr appears 1 cycle after its address is presented.
- IDLE:
  - no capture; instr_valid stays 0.
  - start=1 -> FETCH at the next edge. The first capture occurs on the following edge.
- FETCH, at each edge, priority halt > stall > normal:
  - halt=1: state<=HALTED, instr_valid<=0, pc held.
  - stall=1: pc, instr, instr_pc and instr_valid held. If br_taken=1, latch pend=1, pend_tgt=br_target, pend_annul=br_annul. A later br_taken while stalled overwrites the pending redirect.
  - normal:
    - instr<=rom_data, instr_pc<=pc, instr_valid<=1.
    - redirect r = br_taken ? (br_target, br_annul) : pend ? (pend_tgt, pend_annul) : none. A live br_taken overrides pend.
    - no redirect: pc<=pc+4.
    - redirect: pc<=target with bits[1:0] forced to 0; pend cleared.
    - redirect with annul=1: the word being captured is the delay slot, so instr<=0 and instr_valid<=0.
- Branch timing: br_taken is asserted while the branch is in IF/ID. pc then addresses the delay slot, which is captured unless annulled. The next fetch is the target.
- Wrap: pc=2^ADDR_W-4 with no redirect -> pc=0.
- HALTED: all outputs frozen, instr_valid=0. Exit only via clr=0.
- start is ignored outside IDLE. br_annul is ignored without br_taken.

Decomposition:
- Shared package sparc_fetch_pkg:
  - fetch_state_t enum (IDLE, FETCH, HALTED)
  - INSTR_W=32
  - NOP_WORD=32'h0
  - PC_STEP=4
- Sub-module fetch_redirect_reg holds pend/pend_tgt/pend_annul and the live-vs-pending select. Everything else stays in one module.

Test Plan:
- Reset with clr=0 for 2 cycles -> rom_addr=0, instr_valid=0, state=0.
- Start, then free run with ROM words W0..W3 at 0,4,8,12 -> instr=W0 with instr_pc=0 one cycle after FETCH entry, then W1, W2, W3 on consecutive cycles.
- Branch with delay slot:
  - br_taken=1, br_target=9'd64 (br_annul=0) for one cycle while instr_pc=4 -> next instr is the word at 8 (delay slot, valid), then the word at 64.
  - Repeat with br_annul=1 -> the delay-slot cycle shows instr=0, instr_valid=0, then the word at 64 valid.
- Stall:
  - stall=1 for 3 cycles with br_taken pulsed on the first -> instr, instr_pc and rom_addr held.
  - After release: delay slot is captured, then a fetch from the target.
  - A second br_taken to 128 while stalled overrides -> the target fetched is 128.
- Wrap and halt:
  - pc=508 with no redirect -> next rom_addr=0.
  - halt=1 -> state=2, instr_valid=0, pc frozen for 10 cycles despite start, stall or br_taken.
  - clr=0 -> IDLE, pc=0.
- Reset mid-operation: clr=0 while stalled with a redirect pending -> after start, fetch resumes at 0; the pending target is never used.
